// File: rtl/instruction_fetch.sv
// Instruction fetch front end: single-outstanding IMEM request FSM feeding a
// 2-entry {instr, pc} FIFO toward decode, with flush discard and timeout trap.
//
// state | meaning
// IDLE  | no request outstanding; launch when FIFO has room and no halt/flush
// REQ   | request on IMEM, waiting for ACK; timeout counter running
// ERR   | memory never answered; sticky until reset, FIFO still drains
module instruction_fetch #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        CK_REF,
    input  logic        RST,
    input  logic [31:0] PC_IN,
    input  logic        HALT,
    input  logic        FLUSH,
    output logic        FREEZE_PC,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA,
    output logic        INSTR_VALID,
    output logic [31:0] INSTR_OUT,
    output logic [31:0] INSTR_PC,
    input  logic        DEC_READY,
    output logic        FETCH_ERR
);

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic        r_discard;
    logic [7:0]  r_tmo;
    logic        r_err;
    logic [1:0]  r_cnt;
    logic        r_head;
    logic        r_tail;
    logic [31:0] r_instr [2];
    logic [31:0] r_pc    [2];

    logic        w_launch;
    logic        w_push;
    logic        w_pop;
    logic [7:0]  w_tmo_next;

    // RST gates the launch so FREEZE_PC reads 1 for the whole reset window
    assign w_launch   = (r_state == S_IDLE) && !RST && !HALT && !FLUSH && (r_cnt != 2'd2);
    assign w_push     = (r_state == S_REQ) && IMEM_ACK && !r_discard && !FLUSH;
    assign w_pop      = (r_cnt != 2'd0) && DEC_READY;
    assign w_tmo_next = r_tmo + 8'd1;

    assign FREEZE_PC   = !w_launch;
    assign IMEM_REQ    = (r_state == S_REQ);
    assign IMEM_ADDR   = {r_addr[29:0], 2'b00};
    assign INSTR_VALID = (r_cnt != 2'd0);
    assign INSTR_OUT   = r_instr[r_head];
    assign INSTR_PC    = r_pc[r_head];
    assign FETCH_ERR   = r_err;

    always_ff @(posedge CK_REF) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_addr    <= 32'd0;
            r_discard <= 1'b0;
            r_tmo     <= 8'd0;
            r_err     <= 1'b0;
            r_cnt     <= 2'd0;
            r_head    <= 1'b0;
            r_tail    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_instr[i] <= 32'd0;
                r_pc[i]    <= 32'd0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_state <= S_REQ;
                        r_addr  <= PC_IN;
                        r_tmo   <= 8'd0;
                    end
                end
                S_REQ: begin
                    if (IMEM_ACK) begin
                        r_state   <= S_IDLE;
                        r_discard <= 1'b0;
                    end else begin
                        if (FLUSH) r_discard <= 1'b1;
                        r_tmo <= w_tmo_next;
                        if (w_tmo_next == TMO_LIMIT) begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_ERR: r_state <= S_ERR;
                default: r_state <= S_IDLE;
            endcase

            // a flush wins over any push/pop landing on the same edge
            if (FLUSH) begin
                r_cnt  <= 2'd0;
                r_head <= 1'b0;
                r_tail <= 1'b0;
            end else begin
                if (w_push) begin
                    r_instr[r_tail] <= IMEM_RDATA;
                    r_pc[r_tail]    <= r_addr;
                    r_tail          <= ~r_tail;
                end
                if (w_pop) r_head <= ~r_head;
                case ({w_push, w_pop})
                    2'b10:   r_cnt <= r_cnt + 2'd1;
                    2'b01:   r_cnt <= r_cnt - 2'd1;
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

endmodule
